// File: rtl/riscv_mem_pkg.sv
// Shared types for the I/D-cache main-memory arbiter.
package riscv_mem_pkg;

    localparam int ADDR_W = 28;
    localparam int LINE_W = 128;

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} arb_state_t;

    typedef struct packed {
        logic              read;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } mem_req_t;

    function automatic logic req_valid(mem_req_t r);
        return r.read | r.write;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin pick: on a tie the input not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] | last);
    assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between I-cache and D-cache,
// one transaction per grant, round-robin on ties.
module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int DRAIN_CYC = 1
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [LINE_W-1:0] i_mem_wdata,
    output logic              i_mem_ready,
    output logic [LINE_W-1:0] i_mem_rdata,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [LINE_W-1:0] d_mem_wdata,
    output logic              d_mem_ready,
    output logic [LINE_W-1:0] d_mem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              grant_d
);

    localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    arb_state_t       state;
    logic             last_d;
    logic [CNT_W-1:0] drain_cnt;
    mem_req_t         i_req, d_req, sel;
    logic [1:0]       gnt;

    assign i_req = '{read: i_mem_read, write: i_mem_write, addr: i_mem_addr, wdata: i_mem_wdata};
    assign d_req = '{read: d_mem_read, write: d_mem_write, addr: d_mem_addr, wdata: d_mem_wdata};
    assign sel   = gnt[1] ? d_req : i_req;

    rr_arb2 u_rr (
        .req  ({req_valid(d_req), req_valid(i_req)}),
        .last (last_d),
        .gnt  (gnt)
    );

    // Completion is forwarded only while a transaction is actually in flight.
    assign i_mem_ready = (state == BUSY) & mem_ready & ~grant_d;
    assign d_mem_ready = (state == BUSY) & mem_ready &  grant_d;
    assign i_mem_rdata = mem_rdata;
    assign d_mem_rdata = mem_rdata;

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state     <= IDLE;
            last_d    <= 1'b1;
            grant_d   <= 1'b0;
            drain_cnt <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (|gnt) begin
                    mem_addr  <= sel.addr;
                    mem_wdata <= sel.wdata;
                    mem_write <= sel.write;
                    mem_read  <= sel.read & ~sel.write;
                    grant_d   <= gnt[1];
                    state     <= BUSY;
                end
                BUSY: if (mem_ready) begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    last_d    <= grant_d;
                    drain_cnt <= '0;
                    state     <= DRAIN;
                end
                // Lets the serviced cache drop its strobe before we look again.
                DRAIN: begin
                    if (drain_cnt == CNT_W'(DRAIN_CYC - 1)) state <= IDLE;
                    else drain_cnt <= drain_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter: transaction table plus corner sequences.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         proc_reset_n = 1'b1;
    logic         i_mem_read = 0, i_mem_write = 0, d_mem_read = 0, d_mem_write = 0;
    logic [27:0]  i_mem_addr = '0, d_mem_addr = '0;
    logic [127:0] i_mem_wdata = '0, d_mem_wdata = '0, mem_rdata = '0;
    logic         mem_ready = 0;
    logic         i_mem_ready, d_mem_ready, mem_read, mem_write, grant_d;
    logic [127:0] i_mem_rdata, d_mem_rdata, mem_wdata;
    logic [27:0]  mem_addr;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.DRAIN_CYC(1)) dut (
        .clk(clk), .proc_reset_n(proc_reset_n),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
        .i_mem_wdata(i_mem_wdata), .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
        .d_mem_wdata(d_mem_wdata), .d_mem_ready(d_mem_ready), .d_mem_rdata(d_mem_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant_d(grant_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         ir, iw;
        logic [27:0]  ia;
        logic [127:0] iwd;
        logic         dr, dw;
        logic [27:0]  da;
        logic [127:0] dwd;
        logic [127:0] rdata;
        logic         eg, erd, ewr;
        logic [27:0]  ea;
        logic [127:0] ewd;
    } vec_t;

    localparam logic [127:0] A5 = {16{8'hA5}};
    localparam logic [127:0] LI = {4{32'h1111_0000}};
    localparam logic [127:0] LD = {4{32'hDDDD_0001}};
    localparam logic [127:0] WB = {4{32'hBEEF_0002}};
    localparam logic [127:0] R1 = {4{32'h0F0F_1234}};
    localparam logic [127:0] R2 = {4{32'h5A5A_C3C3}};

    vec_t vecs[10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        i_mem_read = v.ir; i_mem_write = v.iw; i_mem_addr = v.ia; i_mem_wdata = v.iwd;
        d_mem_read = v.dr; d_mem_write = v.dw; d_mem_addr = v.da; d_mem_wdata = v.dwd;
        step();
        chk($sformatf("v%0d grant_d", idx), 128'(grant_d), 128'(v.eg));
        chk($sformatf("v%0d mem_read", idx), 128'(mem_read), 128'(v.erd));
        chk($sformatf("v%0d mem_write", idx), 128'(mem_write), 128'(v.ewr));
        chk($sformatf("v%0d mem_addr", idx), 128'(mem_addr), 128'(v.ea));
        chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.ewd);
        step();
        step();
        mem_rdata = v.rdata;
        mem_ready = 1'b1;
        #1;
        chk($sformatf("v%0d i_ready", idx), 128'(i_mem_ready), 128'(!v.eg));
        chk($sformatf("v%0d d_ready", idx), 128'(d_mem_ready), 128'(v.eg));
        chk($sformatf("v%0d rdata", idx), v.eg ? d_mem_rdata : i_mem_rdata, v.rdata);
        step();
        mem_ready = 1'b0;
        chk($sformatf("v%0d strobes_r1", idx), 128'({mem_read, mem_write}), 128'(0));
        step();
        chk($sformatf("v%0d strobes_r2", idx), 128'({mem_read, mem_write}), 128'(0));
    endtask

    task automatic clear_reqs();
        i_mem_read = 0; i_mem_write = 0; d_mem_read = 0; d_mem_write = 0;
    endtask

    initial begin
        //            ir iw ia         iwd dr dw da           dwd rdata eg erd ewr ea           ewd
        vecs[0] = '{1, 0, 28'h0000010, LI, 0, 0, 28'h0,       LD, A5, 0, 1, 0, 28'h0000010, LI};
        vecs[1] = '{1, 0, 28'h0000020, LI, 0, 1, 28'h0000300, LD, R1, 1, 0, 1, 28'h0000300, LD};
        vecs[2] = '{1, 0, 28'h0000020, LI, 0, 1, 28'h0000300, LD, R2, 0, 1, 0, 28'h0000020, LI};
        vecs[3] = '{1, 0, 28'h0000020, LI, 0, 1, 28'h0000300, LD, R1, 1, 0, 1, 28'h0000300, LD};
        vecs[4] = '{1, 0, 28'h0000020, LI, 0, 1, 28'h0000300, LD, R2, 0, 1, 0, 28'h0000020, LI};
        vecs[5] = '{1, 0, 28'h0000080, LI, 0, 1, 28'h1234560, WB, R1, 1, 0, 1, 28'h1234560, WB};
        vecs[6] = '{1, 0, 28'h0000080, LI, 1, 0, 28'h0000040, WB, R2, 0, 1, 0, 28'h0000080, LI};
        vecs[7] = '{1, 0, 28'h0000080, LI, 1, 0, 28'h0000040, WB, A5, 1, 1, 0, 28'h0000040, WB};
        vecs[8] = '{0, 0, 28'h0000080, LI, 1, 1, 28'h0000abc, LD, R1, 1, 0, 1, 28'h0000abc, LD};
        vecs[9] = '{0, 1, 28'h0000def, LI, 0, 0, 28'h0000040, LD, R2, 0, 0, 1, 28'h0000def, LI};

        #2 proc_reset_n = 1'b0;
        #1;
        chk("reset strobes", 128'({mem_read, mem_write}), 128'(0));
        chk("reset addr", 128'(mem_addr), 128'(0));
        chk("reset wdata", mem_wdata, 128'(0));
        chk("reset grant_d", 128'(grant_d), 128'(0));
        step();
        proc_reset_n = 1'b1;
        step();

        // Spurious completion while idle.
        mem_ready = 1'b1;
        #1;
        chk("idle spurious ready", 128'({i_mem_ready, d_mem_ready}), 128'(0));
        step();
        mem_ready = 1'b0;
        chk("idle spurious strobes", 128'({mem_read, mem_write}), 128'(0));

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);
        clear_reqs();
        step();

        // Reset mid-BUSY, then late mem_ready, then a tie must favour I.
        d_mem_read = 1; d_mem_addr = 28'h000003C;
        step();
        chk("rst pre mem_read", 128'(mem_read), 128'(1));
        chk("rst pre grant_d", 128'(grant_d), 128'(1));
        #2 proc_reset_n = 1'b0;
        #1;
        chk("rst async mem_read", 128'(mem_read), 128'(0));
        chk("rst async addr", 128'(mem_addr), 128'(0));
        chk("rst async grant_d", 128'(grant_d), 128'(0));
        clear_reqs();
        step();
        proc_reset_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("rst late ready", 128'({i_mem_ready, d_mem_ready}), 128'(0));
        step();
        mem_ready = 1'b0;
        chk("rst late strobes", 128'({mem_read, mem_write}), 128'(0));
        i_mem_read = 1; i_mem_addr = 28'h00000A0;
        d_mem_read = 1; d_mem_addr = 28'h00000B0;
        step();
        chk("rst tie grant_d", 128'(grant_d), 128'(0));
        chk("rst tie addr", 128'(mem_addr), 128'(28'h00000A0));
        step();
        mem_ready = 1'b1;
        #1;
        chk("rst tie i_ready", 128'(i_mem_ready), 128'(1));
        step();
        mem_ready = 1'b0;
        clear_reqs();
        step();

        // Requester changes inputs mid-BUSY; downstream must hold.
        i_mem_read = 1; i_mem_addr = 28'h0000055;
        step();
        i_mem_read = 0; i_mem_addr = 28'h0000099;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("hold%0d mem_read", k), 128'(mem_read), 128'(1));
            chk($sformatf("hold%0d addr", k), 128'(mem_addr), 128'(28'h0000055));
        end
        mem_ready = 1'b1;
        #1;
        chk("hold i_ready", 128'(i_mem_ready), 128'(1));
        chk("hold d_ready", 128'(d_mem_ready), 128'(0));
        step();
        // mem_ready still high here: a spurious pulse while draining.
        #1;
        chk("drain spurious ready", 128'({i_mem_ready, d_mem_ready}), 128'(0));
        step();
        mem_ready = 1'b0;
        chk("drain spurious strobes", 128'({mem_read, mem_write}), 128'(0));
        d_mem_read = 1; d_mem_addr = 28'h0000088;
        step();
        chk("post drain grant_d", 128'(grant_d), 128'(1));
        chk("post drain mem_read", 128'(mem_read), 128'(1));
        chk("post drain addr", 128'(mem_addr), 128'(28'h0000088));
        mem_ready = 1'b1;
        #1;
        chk("post drain d_ready", 128'(d_mem_ready), 128'(1));
        step();
        mem_ready = 1'b0;
        clear_reqs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
